// File: rtl/multdiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// The MULTDIV_RADIX4_EN macro selects radix-4 Booth multiply with 16 iterations.
// Without it, multiply uses radix-2 Booth with 32 iterations.
package multdiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_e;

`ifdef MULTDIV_RADIX4_EN
    localparam logic [5:0] MULT_ITERS = 6'd16;
`else
    localparam logic [5:0] MULT_ITERS = 6'd32;
`endif
    localparam logic [5:0]  DIV_ITERS = 6'd32;
    localparam logic [31:0] INT_MIN   = 32'h8000_0000;

    // Magnitude of a two's complement word. INT_MIN maps to 0x80000000 as an unsigned value.
    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/multdiv_addsub33.sv
// 33-bit adder/subtractor with carry-out.
// Shared by the Booth accumulate step and the restoring-division trial subtract.
module multdiv_addsub33 (
    input  logic [32:0] a,
    input  logic [32:0] b,
    input  logic        sub,
    output logic [32:0] sum,
    output logic        cout
);

    logic [33:0] total;

    // a + b, or a - b as a + ~b + 1. When subtracting, cout=1 means no borrow.
    always_comb begin
        total = {1'b0, a} + {1'b0, (sub ? ~b : b)} + {33'd0, sub};
        sum   = total[32:0];
        cout  = total[33];
    end

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed 32-bit multiply/divide unit behind a start/ready handshake.
// MULTDIV_RADIX4_EN selects radix-4 Booth multiply (16 iterations).
// The default build uses radix-2 Booth multiply (32 iterations).
// Divide is always restoring division on operand magnitudes, 32 iterations.
module multdiv_unit
    import multdiv_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY
);

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] acc_q, acc_d;      // Booth A register, or the division remainder
    logic [31:0] q_q, q_d;          // multiplier / product low word, or quotient
    logic        qm1_q, qm1_d;      // Booth q-1 bit
    logic [31:0] m_q, m_d;          // multiplicand, or divisor magnitude
    logic        neg_q, neg_d;      // quotient must be negated
    logic        dexc_q, dexc_d;    // divide exception detected at start
    logic [31:0] result_q, result_d;
    logic        exc_q, exc_d;
    logic        rdy_q, rdy_d;

    logic        start;
    logic [32:0] add_a, add_b, add_sum;
    logic        add_sub, add_cout;
    logic [63:0] prod;
    logic [31:0] quot;
`ifdef MULTDIV_RADIX4_EN
    logic        two_m;
    logic [33:0] r4_val;
`endif

    assign start = ctrl_MULT | ctrl_DIV;

    multdiv_addsub33 u_addsub (
        .a    (add_a),
        .b    (add_b),
        .sub  (add_sub),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Adder operand selection: Booth recoding in MUL, trial subtract in DIV.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_sub = 1'b0;
`ifdef MULTDIV_RADIX4_EN
        two_m   = 1'b0;
`endif
        case (state_q)
            MUL: begin
`ifdef MULTDIV_RADIX4_EN
                // A +/- 2M is formed as 2*((A>>>1) +/- M) + A[0] so it fits the 33-bit adder.
                case ({q_q[1:0], qm1_q})
                    3'b001, 3'b010: add_b = {m_q[31], m_q};
                    3'b011: begin
                        two_m = 1'b1;
                        add_b = {m_q[31], m_q};
                    end
                    3'b100: begin
                        two_m   = 1'b1;
                        add_sub = 1'b1;
                        add_b   = {m_q[31], m_q};
                    end
                    3'b101, 3'b110: begin
                        add_sub = 1'b1;
                        add_b   = {m_q[31], m_q};
                    end
                    default: add_b = '0;
                endcase
                add_a = two_m ? {{2{acc_q[31]}}, acc_q[31:1]} : {acc_q[31], acc_q};
`else
                add_a = {acc_q[31], acc_q};
                case ({q_q[0], qm1_q})
                    2'b01: add_b = {m_q[31], m_q};
                    2'b10: begin
                        add_sub = 1'b1;
                        add_b   = {m_q[31], m_q};
                    end
                    default: add_b = '0;
                endcase
`endif
            end
            DIV: begin
                // The shifted partial remainder is 33 bits wide.
                add_a   = {acc_q, q_q[31]};
                add_b   = {1'b0, m_q};
                add_sub = 1'b1;
            end
            default: begin
                add_a = '0;
            end
        endcase
    end

    // Next-state, iteration and result logic. A start in any state restarts the unit.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        q_d      = q_q;
        qm1_d    = qm1_q;
        m_d      = m_q;
        neg_d    = neg_q;
        dexc_d   = dexc_q;
        result_d = result_q;
        exc_d    = exc_q;
        rdy_d    = 1'b0;
        prod     = {acc_q, q_q};
        quot     = neg_q ? (~q_q + 32'd1) : q_q;
`ifdef MULTDIV_RADIX4_EN
        r4_val   = two_m ? {add_sum, acc_q[0]} : {add_sum[32], add_sum};
`endif
        if (start) begin
            cnt_d = '0;
            acc_d = '0;
            qm1_d = 1'b0;
            if (ctrl_MULT) begin
                state_d = MUL;
                q_d     = data_operandB;
                m_d     = data_operandA;
            end else begin
                state_d = DIV;
                q_d     = abs32(data_operandA);
                m_d     = abs32(data_operandB);
                neg_d   = data_operandA[31] ^ data_operandB[31];
                dexc_d  = (data_operandB == 32'd0) ||
                          ((data_operandA == INT_MIN) && (data_operandB == 32'hFFFF_FFFF));
            end
        end else begin
            case (state_q)
                MUL: begin
                    if (cnt_q == MULT_ITERS) begin
                        state_d  = DONE;
                        result_d = prod[31:0];
                        exc_d    = (prod[63:31] != {33{prod[63]}});
                        rdy_d    = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
`ifdef MULTDIV_RADIX4_EN
                        acc_d = r4_val[33:2];
                        q_d   = {r4_val[1:0], q_q[31:2]};
                        qm1_d = q_q[1];
`else
                        acc_d = add_sum[32:1];
                        q_d   = {add_sum[0], q_q[31:1]};
                        qm1_d = q_q[0];
`endif
                    end
                end
                DIV: begin
                    if (cnt_q == DIV_ITERS) begin
                        state_d  = DONE;
                        result_d = dexc_q ? 32'd0 : quot;
                        exc_d    = dexc_q;
                        rdy_d    = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                        if (add_cout) begin
                            acc_d = add_sum[31:0];
                            q_d   = {q_q[30:0], 1'b1};
                        end else begin
                            acc_d = add_a[31:0];
                            q_d   = {q_q[30:0], 1'b0};
                        end
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // All state and registered outputs; asynchronous reset returns to IDLE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            q_q      <= '0;
            qm1_q    <= 1'b0;
            m_q      <= '0;
            neg_q    <= 1'b0;
            dexc_q   <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            q_q      <= q_d;
            qm1_q    <= qm1_d;
            m_q      <= m_d;
            neg_q    <= neg_d;
            dexc_q   <= dexc_d;
            result_q <= result_d;
            exc_q    <= exc_d;
            rdy_q    <= rdy_d;
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed testbench for multdiv_unit. Honours MULTDIV_RADIX4_EN for multiply latency.
`timescale 1ns/1ps
module tb_multdiv_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    int checks = 0;
    int errors = 0;

`ifdef MULTDIV_RADIX4_EN
    localparam int MUL_LAT = 17;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    always #5 clock = ~clock;

    multdiv_unit dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present a start for one edge (E0); operands are scrambled afterwards.
    task automatic issue(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        data_operandA = a;
        data_operandB = b;
        @(posedge clock);
        #1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    // Count edges after E0 until ready; records first pulse and whether result held before it.
    task automatic wait_rdy(input int limit, input bit stop_first, input logic [31:0] hold,
                            output int lat, output int pulses, output logic [31:0] res,
                            output logic exc, output bit stable);
        lat    = -1;
        pulses = 0;
        res    = '0;
        exc    = 1'b0;
        stable = 1'b1;
        for (int k = 1; k <= limit; k++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) begin
                if (pulses == 0) begin
                    lat = k;
                    res = data_result;
                    exc = data_exception;
                end
                pulses++;
                if (stop_first) break;
            end else if (pulses == 0 && data_result !== hold) begin
                stable = 1'b0;
            end
        end
    endtask

    task automatic run_op(input string tag, input logic m, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input logic exp_exc);
        int lat, pulses, exp_lat;
        logic [31:0] res;
        logic exc;
        bit stable;
        exp_lat = m ? MUL_LAT : DIV_LAT;
        issue(m, ~m, a, b);
        wait_rdy(exp_lat + 4, 1'b0, 32'd0, lat, pulses, res, exc, stable);
        $display("op %s: A=0x%08h B=0x%08h result=0x%08h exc=%0b lat=%0d pulses=%0d",
                 tag, a, b, res, exc, lat, pulses);
        check({tag, "/result"}, res, exp_res);
        check({tag, "/exc"}, {31'd0, exc}, {31'd0, exp_exc});
        check({tag, "/lat"}, lat, exp_lat);
        check({tag, "/pulses"}, pulses, 32'd1);
    endtask

    initial begin
        int lat, pulses, cnt;
        logic [31:0] res;
        logic exc;
        bit stable;

        reset         = 1'b1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        repeat (3) @(posedge clock);
        #1;
        check("reset/result", data_result, 32'd0);
        check("reset/exc", {31'd0, data_exception}, 32'd0);
        check("reset/rdy", {31'd0, data_resultRDY}, 32'd0);
        $display("op reset: result=0x%08h exc=%0b rdy=%0b", data_result, data_exception, data_resultRDY);
        @(negedge clock);
        reset = 1'b0;

        // Multiply vectors
        run_op("mul_7x-3",       1'b1, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
        run_op("mul_2^16x2^16",  1'b1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1);
        run_op("mul_maxx1",      1'b1, 32'h7FFF_FFFF, 32'd1,         32'h7FFF_FFFF, 1'b0);
        run_op("mul_-1x-1",      1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         1'b0);
        run_op("mul_minx-1",     1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
        run_op("mul_minx1",      1'b1, 32'h8000_0000, 32'd1,         32'h8000_0000, 1'b0);
        run_op("mul_minxmin",    1'b1, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1);
        run_op("mul_-65536x32768", 1'b1, 32'hFFFF_0000, 32'h0000_8000, 32'h8000_0000, 1'b0);
        run_op("mul_12345678x16", 1'b1, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 1'b1);

        // Divide vectors
        run_op("div_-100/7",     1'b0, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2, 1'b0);
        run_op("div_5/0",        1'b0, 32'd5,         32'd0,         32'd0,         1'b1);
        run_op("div_min/-1",     1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b1);
        run_op("div_7/-2",       1'b0, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0);
        run_op("div_min/1",      1'b0, 32'h8000_0000, 32'd1,         32'h8000_0000, 1'b0);
        run_op("div_0/5",        1'b0, 32'd0,         32'd5,         32'd0,         1'b0);
        run_op("div_1000000/3",  1'b0, 32'd1000000,   32'd3,         32'h0005_1615, 1'b0);

        // Abort: multiply 3x4 restarted by divide 20/5 on edge 10
        issue(1'b1, 1'b0, 32'd3, 32'd4);
        cnt = 0;
        repeat (9) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) cnt++;
        end
        issue(1'b0, 1'b1, 32'd20, 32'd5);
        wait_rdy(DIV_LAT + 4, 1'b0, 32'd0, lat, pulses, res, exc, stable);
        $display("op abort: result=0x%08h exc=%0b lat=%0d pulses=%0d early=%0d", res, exc, lat, pulses, cnt);
        check("abort/early_rdy", cnt, 32'd0);
        check("abort/result", res, 32'd4);
        check("abort/lat", lat, DIV_LAT);
        check("abort/pulses", pulses, 32'd1);

        // Same-edge start: multiply wins
        issue(1'b1, 1'b1, 32'd6, 32'd3);
        wait_rdy(MUL_LAT + 4, 1'b0, 32'd0, lat, pulses, res, exc, stable);
        $display("op both: result=0x%08h exc=%0b lat=%0d pulses=%0d", res, exc, lat, pulses);
        check("both/result", res, 32'd18);
        check("both/lat", lat, MUL_LAT);
        check("both/pulses", pulses, 32'd1);

        // Reset mid-operation: result currently nonzero from the last run
        issue(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
        repeat (14) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("midrst/result", data_result, 32'd0);
        check("midrst/exc", {31'd0, data_exception}, 32'd0);
        check("midrst/rdy", {31'd0, data_resultRDY}, 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        wait_rdy(MUL_LAT + 8, 1'b0, 32'd0, lat, pulses, res, exc, stable);
        $display("op midrst: pulses_after_reset=%0d result=0x%08h", pulses, data_result);
        check("midrst/no_rdy", pulses, 32'd0);
        run_op("post_rst_7x-3", 1'b1, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);

        // Back-to-back: second start in the ready cycle of the first
        issue(1'b1, 1'b0, 32'h7FFF_FFFF, 32'd1);
        wait_rdy(MUL_LAT + 4, 1'b1, 32'hFFFF_FFEB, lat, pulses, res, exc, stable);
        $display("op b2b_first: result=0x%08h exc=%0b lat=%0d", res, exc, lat);
        check("b2b1/result", res, 32'h7FFF_FFFF);
        check("b2b1/lat", lat, MUL_LAT);
        issue(1'b0, 1'b1, 32'hFFFF_FF9C, 32'd7);
        wait_rdy(DIV_LAT + 4, 1'b0, 32'h7FFF_FFFF, lat, pulses, res, exc, stable);
        $display("op b2b_second: result=0x%08h exc=%0b lat=%0d pulses=%0d stable=%0b",
                 res, exc, lat, pulses, stable);
        check("b2b2/result", res, 32'hFFFF_FFF2);
        check("b2b2/lat", lat, DIV_LAT);
        check("b2b2/pulses", pulses, 32'd1);
        check("b2b2/stable", {31'd0, stable}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
